bus_parity_receiver: RTL
========================

// Module: bus_parity_receiver
// PURPOSE
//  Far-end receiver for the inverted (active-low, wired-AND) parity bus driven by the bus transceivers.
//  Captures one WIDTH-bit word per four-phase strobe/acknowledge handshake and checks it against the
//  transmitted parity line. Queues each word with its parity-error flag in a show-ahead FIFO for the
//  local consumer. Withholds acknowledge when the FIFO is full, which back-pressures the transmitter.
// PARAMETERS
//  WIDTH  4  data bits on the bus
//  DEPTH  4  FIFO entries; must be a power of 2, >= 2
//  AW     2  log2(DEPTH); the instantiator sets it consistent with DEPTH
// PORTS
//  cp     in   1        clock; all state changes on rising edge
//  rst_   in   1        asynchronous, active-low reset
//  bus_   in   WIDTH    inverted bus data; true data = ~bus_
//  par    in   1        transmitted parity, active-high; par == ^(~bus_) for a good word
//  stb_   in   1        transmitter strobe, active-low, asynchronous to cp
//  ack_   out  1        acknowledge to transmitter, active-low, registered
//  rd     in   1        consumer pop of FIFO head; ignored when empty
//  r      out  WIDTH    FIFO head data, true polarity (show-ahead)
//  perr   out  1        parity-error flag of the FIFO head
//  empty  out  1        FIFO holds no entries
//  full   out  1        FIFO holds DEPTH entries
//  count  out  AW+1     number of entries, 0..DEPTH
//  perr_any out 1       sticky: set by any captured word with bad parity; cleared by clr
//  clr    in   1        synchronous clear of perr_any
// BEHAVIOUR
//  Reset: ack_=1, empty=1, full=0, count=0, r=0, perr=0, perr_any=0, FIFO storage=0, FSM=ARM.
//   The two-flop stb_ synchronizer resets to 0 (asserted view).
//  ss = stb_ after the 2-flop synchronizer. This gives 2 cp of latency from a stb_ edge to FSM visibility.
//  FSM:
//   ARM  : ss==1 -> IDLE. Blocks re-capture of a strobe still held across a reset.
//   IDLE : ss==0 && !full -> ACK. On this same edge, write {~bus_, par ^ ^(~bus_)} to the FIFO tail.
//          ack_ goes 0 on this edge. perr_any |= error bit.
//          ss==0 && full -> stay in IDLE, no write, ack_ stays 1 (back-pressure).
//   ACK  : ack_ held 0; ss==1 -> IDLE with ack_=1 on that edge.
//  Exactly one FIFO write per handshake. bus_/par are not synchronized: they must be stable from
//   before stb_ falls until ack_ falls.
//  Full check uses registered count at the edge. A rd on the same edge as a blocked capture does not
//   unblock it; capture occurs on the next edge.
//  rd && !empty pops the head. Simultaneous write and pop: count unchanged, both pointers advance.
//  rd when empty: no effect.
//  Pointers are AW bits and wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0), both registered.
//  r/perr are combinational reads of storage[rd_ptr]. When empty they show stale storage (0 after reset).
//  clr and a bad-parity capture on the same edge: perr_any ends at 1 (set wins).
//  Reset asserted mid-handshake: ack_ goes 1 immediately, FIFO is emptied, FSM=ARM.
// STRUCTURE
//  Shared header bus_defs.vh: FSM state localparams ST_ARM=2'd0, ST_IDLE=2'd1, ST_ACK=2'd2.
//   The same codes are used by the matching transmitter sequencer.
//  Sub-module bus_rx_fifo (WIDTH+1 bits wide, DEPTH deep, show-ahead, async active-low reset).
//   It owns the pointers, count, full, and empty.
//  The synchronizer and FSM stay inline in this module.
// TESTING
//  1 Reset, hold stb_=1 for 3 cp -> FSM IDLE, ack_=1, empty=1, count=0.
//  2 bus_=4'b1010 (data 0101), par=0, stb_ low -> ack_ low within 3 cp. Then raise stb_ -> ack_ high
//    within 3 cp. Result: r=4'h5, perr=0, count=1.
//  3 Data 0x7 with par=0 -> perr=1, perr_any=1. Pulse clr -> perr_any=0, and perr stays 1 at the head.
//  4 Send 5 words 1,2,3,4,5 without rd -> 4 acked, full=1, ack_ stays 1 on the 5th. Pulse rd ->
//    5th acked, head order 2,3,4,5.
//  5 rd on an empty FIFO -> count stays 0, no underflow. rd and a capture on the same edge with count=2
//    -> count stays 2.
//  6 Assert rst_ with ack_=0 and stb_ still low -> ack_=1 at once, no new capture until stb_ rises and
//    falls again.

Source files
------------

// File: rtl/bus_parity_receiver_pkg.sv
// bus_parity_receiver_pkg: FSM state codes for the parity bus receiver.
// These codes match the ones used by the transmitter sequencer.
package bus_parity_receiver_pkg;
  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACK  = 2'd2
  } rx_state_e;
endpackage

// File: rtl/bus_rx_fifo.sv
// bus_rx_fifo: show-ahead FIFO that owns the pointers, count, full and empty.
module bus_rx_fifo #(
  parameter int DW    = 5,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          cp,
  input  logic          rst_,
  input  logic          we,
  input  logic [DW-1:0] wd,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q, pop;
  assign pop     = rd && !empty_q;
  assign count_d = count_q + {{AW{1'b0}}, we} - {{AW{1'b0}}, pop};
  assign rdata   = mem_q[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  always_ff @(posedge cp or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (we) mem_q[wr_ptr_q] <= wd;
      wr_ptr_q <= wr_ptr_q + AW'(we);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_d;
      empty_q  <= count_d == '0;
      full_q   <= count_d == (AW+1)'(DEPTH);
    end
  end
endmodule

// File: rtl/bus_parity_receiver.sv
// bus_parity_receiver: captures one inverted-bus word per strobe/ack handshake,
// checks its parity and queues {data, error} for the local consumer.
module bus_parity_receiver
  import bus_parity_receiver_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             cp,
  input  logic             rst_,
  input  logic [WIDTH-1:0] bus_,
  input  logic             par,
  input  logic             stb_,
  output logic             ack_,
  input  logic             rd,
  output logic [WIDTH-1:0] r,
  output logic             perr,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             perr_any,
  input  logic             clr
);
  rx_state_e        state_q, state_d;
  logic             s1_q, ss_q, ack_q, perr_any_q, perr_any_d, we, err;
  logic [WIDTH:0]   rdata;
  logic [WIDTH-1:0] data;
  assign data = ~bus_;
  assign err  = par ^ (^data);
  always_comb begin
    we         = state_q == ST_IDLE && !ss_q && !full;
    state_d    = state_q == ST_ARM  ? (ss_q ? ST_IDLE : ST_ARM) :
                 state_q == ST_IDLE ? (we ? ST_ACK : ST_IDLE) :
                                      (ss_q ? ST_IDLE : ST_ACK);
    perr_any_d = (perr_any_q && !clr) || (we && err);
  end
  // The synchronizer resets to the asserted view so a strobe held over reset is not re-captured.
  always_ff @(posedge cp or negedge rst_) begin
    if (!rst_) begin
      s1_q       <= 1'b0;
      ss_q       <= 1'b0;
      state_q    <= ST_ARM;
      ack_q      <= 1'b1;
      perr_any_q <= 1'b0;
    end else begin
      s1_q       <= stb_;
      ss_q       <= s1_q;
      state_q    <= state_d;
      ack_q      <= state_d != ST_ACK;
      perr_any_q <= perr_any_d;
    end
  end
  bus_rx_fifo #(.DW(WIDTH + 1), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .cp    (cp),
    .rst_  (rst_),
    .we    (we),
    .wd    ({data, err}),
    .rd    (rd),
    .rdata (rdata),
    .empty (empty),
    .full  (full),
    .count (count)
  );
  assign ack_     = ack_q;
  assign r        = rdata[WIDTH:1];
  assign perr     = rdata[0];
  assign perr_any = perr_any_q;
endmodule
